// File: rtl/mips_debug_frame_streamer.sv
// mips_debug_frame_streamer
// MIPS-side responder of the debug link. Decodes a request select, snapshots
// the addressed source (register, PC, data/instr memory word or a pipeline
// latch group) and streams it out as NB_FRAME-bit frames, most significant
// word first, followed by a one-cycle end-of-data pulse.
//
// Ports:
//   i_clock, i_reset     clock, asynchronous active-high reset
//   i_request_select     request code, 6'h3F = no request
//   i_reg_data           reg-file debug read data for o_reg_addr
//   i_pc                 current PC
//   i_mem_data           data-memory read word
//   i_instr_data         instruction-memory read word
//   i_latch_bus          N_LATCH pipeline latch groups, group k at [k*NB_LATCH +: NB_LATCH]
//   o_reg_addr           reg-file debug read address
//   o_frame              data frame (zero when o_frame_valid is low)
//   o_frame_valid        o_frame carries a data word
//   o_eod                end of data, one-cycle pulse
//   o_busy               transfer in progress
module mips_debug_frame_streamer #(
    parameter int unsigned NB_FRAME = 32,
    parameter int unsigned NB_REG   = 32,
    parameter int unsigned NB_LATCH = 96,
    parameter int unsigned N_LATCH  = 8,
    parameter int unsigned NB_SEL   = 6
) (
    input  logic                        i_clock,
    input  logic                        i_reset,
    input  logic [NB_SEL-1:0]           i_request_select,
    input  logic [NB_REG-1:0]           i_reg_data,
    input  logic [NB_REG-1:0]           i_pc,
    input  logic [NB_REG-1:0]           i_mem_data,
    input  logic [NB_REG-1:0]           i_instr_data,
    input  logic [N_LATCH*NB_LATCH-1:0] i_latch_bus,
    output logic [4:0]                  o_reg_addr,
    output logic [NB_FRAME-1:0]         o_frame,
    output logic                        o_frame_valid,
    output logic                        o_eod,
    output logic                        o_busy
);

    localparam int unsigned N_WORDS = NB_LATCH / NB_FRAME;
    localparam int unsigned NB_CNT  = $clog2(N_WORDS) + 1;
    localparam int unsigned NB_GIDX = (N_LATCH > 1) ? $clog2(N_LATCH) : 1;

    localparam logic [NB_SEL-1:0] SEL_MEM     = NB_SEL'(6'h20);
    localparam logic [NB_SEL-1:0] SEL_INSTR   = NB_SEL'(6'h21);
    localparam logic [NB_SEL-1:0] SEL_PC      = NB_SEL'(6'h22);
    localparam logic [NB_SEL-1:0] SEL_LATCH0  = NB_SEL'(6'h24);
    localparam logic [NB_SEL-1:0] SEL_LATCH_N = NB_SEL'(6'h24 + N_LATCH - 1);
    localparam logic [NB_SEL-1:0] SEL_NONE    = NB_SEL'(6'h3F);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SEND,
        ST_EOD
    } state_t;

    state_t                state_q, state_nxt;
    logic [NB_SEL-1:0]     sel_q, sel_nxt;
    logic [NB_CNT-1:0]     cnt_q, cnt_nxt;
    logic [NB_LATCH-1:0]   shift_q, shift_nxt;
    logic [4:0]            reg_addr_nxt;
    logic [NB_FRAME-1:0]   frame_nxt;
    logic                  valid_nxt;
    logic                  eod_nxt;
    logic                  busy_nxt;

    logic                  req_word;
    logic                  req_latch;
    logic [NB_GIDX-1:0]    grp_idx;
    logic [NB_LATCH-1:0]   grp_snap;
    logic                  src_is_word;
    logic [NB_REG-1:0]     src_word;
    logic [NB_LATCH-1:0]   load_vec;

    // Request classification of the live select
    always_comb begin
        req_word  = !i_request_select[NB_SEL-1] ||
                    (i_request_select == SEL_MEM) ||
                    (i_request_select == SEL_INSTR) ||
                    (i_request_select == SEL_PC);
        req_latch = (i_request_select >= SEL_LATCH0) && (i_request_select <= SEL_LATCH_N);
        grp_idx   = NB_GIDX'(i_request_select - SEL_LATCH0);
    end

    // Latch group mux for the accept-edge snapshot
    always_comb begin
        grp_snap = '0;
        for (int k = 0; k < int'(N_LATCH); k++) begin
            if (grp_idx == NB_GIDX'(k)) begin
                grp_snap = i_latch_bus[k*NB_LATCH +: NB_LATCH];
            end
        end
    end

    // One-word source selected by the accepted request, sampled at the LOAD edge
    always_comb begin
        src_is_word = 1'b1;
        src_word    = '0;
        if (!sel_q[NB_SEL-1]) begin
            src_word = i_reg_data;
        end else begin
            case (sel_q)
                SEL_MEM:   src_word = i_mem_data;
                SEL_INSTR: src_word = i_instr_data;
                SEL_PC:    src_word = i_pc;
                default:   src_is_word = 1'b0;
            endcase
        end
        load_vec = shift_q;
        if (src_is_word) begin
            load_vec = '0;
            load_vec[NB_LATCH-1 -: NB_REG] = src_word;
        end
    end

    // Next-state and registered-output logic
    always_comb begin
        state_nxt    = state_q;
        sel_nxt      = sel_q;
        cnt_nxt      = cnt_q;
        shift_nxt    = shift_q;
        reg_addr_nxt = o_reg_addr;
        frame_nxt    = '0;
        valid_nxt    = 1'b0;
        eod_nxt      = 1'b0;
        busy_nxt     = o_busy;

        case (state_q)
            ST_IDLE: begin
                if (i_request_select != SEL_NONE) begin
                    sel_nxt      = i_request_select;
                    reg_addr_nxt = i_request_select[4:0];
                    busy_nxt     = 1'b1;
                    if (req_word) begin
                        cnt_nxt   = NB_CNT'(1);
                        shift_nxt = '0;
                        state_nxt = ST_LOAD;
                    end else if (req_latch) begin
                        cnt_nxt   = NB_CNT'(N_WORDS);
                        shift_nxt = grp_snap;
                        state_nxt = ST_LOAD;
                    end else begin
                        // Unknown code: answer with an empty transfer
                        eod_nxt   = 1'b1;
                        state_nxt = ST_EOD;
                    end
                end
            end
            ST_LOAD: begin
                frame_nxt = load_vec[NB_LATCH-1 -: NB_FRAME];
                valid_nxt = 1'b1;
                shift_nxt = load_vec << NB_FRAME;
                cnt_nxt   = cnt_q - NB_CNT'(1);
                state_nxt = ST_SEND;
            end
            ST_SEND: begin
                if (cnt_q != '0) begin
                    frame_nxt = shift_q[NB_LATCH-1 -: NB_FRAME];
                    valid_nxt = 1'b1;
                    shift_nxt = shift_q << NB_FRAME;
                    cnt_nxt   = cnt_q - NB_CNT'(1);
                end else begin
                    eod_nxt   = 1'b1;
                    state_nxt = ST_EOD;
                end
            end
            ST_EOD: begin
                busy_nxt  = 1'b0;
                state_nxt = ST_IDLE;
            end
            default: begin
                busy_nxt  = 1'b0;
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state_q       <= ST_IDLE;
            sel_q         <= '0;
            cnt_q         <= '0;
            shift_q       <= '0;
            o_reg_addr    <= '0;
            o_frame       <= '0;
            o_frame_valid <= 1'b0;
            o_eod         <= 1'b0;
            o_busy        <= 1'b0;
        end else begin
            state_q       <= state_nxt;
            sel_q         <= sel_nxt;
            cnt_q         <= cnt_nxt;
            shift_q       <= shift_nxt;
            o_reg_addr    <= reg_addr_nxt;
            o_frame       <= frame_nxt;
            o_frame_valid <= valid_nxt;
            o_eod         <= eod_nxt;
            o_busy        <= busy_nxt;
        end
    end

endmodule
